// File: rtl/apb_master.sv
// APB requester: turns a host valid/ready command into an APB SETUP->ACCESS
// transfer and answers with a one-cycle response pulse (read data or timeout).
// Only one transfer is outstanding at a time.
module apb_master #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MIN_ACCESS = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          p_sel,
  output logic          p_enable,
  output logic          p_w_en,
  output logic [AW-1:0] p_add,
  output logic [DW-1:0] p_wdata,
  input  logic          p_ready,
  input  logic [DW-1:0] p_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_ACCESS);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] acc_cnt, acc_cnt_nx;
  logic          p_sel_nx, p_enable_nx, p_w_en_nx;
  logic [AW-1:0] p_add_nx;
  logic [DW-1:0] p_wdata_nx;
  logic          rsp_valid_nx, rsp_err_nx;
  logic [DW-1:0] rsp_rdata_nx;
  logic          accept;

  // Ready only while idle and out of reset; reset gates it combinationally.
  assign cmd_ready = rst & (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // Next-state and next-output logic. p_w_en doubles as the latched
  // write flag, since it only changes on accept.
  always_comb begin
    state_nx     = state;
    acc_cnt_nx   = acc_cnt;
    p_sel_nx     = p_sel;
    p_enable_nx  = p_enable;
    p_w_en_nx    = p_w_en;
    p_add_nx     = p_add;
    p_wdata_nx   = p_wdata;
    rsp_valid_nx = 1'b0;
    rsp_err_nx   = 1'b0;
    rsp_rdata_nx = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx    = SETUP;
          acc_cnt_nx  = '0;
          p_sel_nx    = 1'b1;
          p_enable_nx = 1'b0;
          p_w_en_nx   = cmd_write;
          p_add_nx    = cmd_addr;
          p_wdata_nx  = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_nx    = ACCESS;
        p_enable_nx = 1'b1;
        acc_cnt_nx  = CW'(1);
      end
      ACCESS: begin
        // A ready seen before MIN_ACCESS cycles may be stale from the
        // previous transfer, so it is ignored.
        if (acc_cnt >= MIN_C && p_ready) begin
          state_nx     = IDLE;
          acc_cnt_nx   = '0;
          p_sel_nx     = 1'b0;
          p_enable_nx  = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = p_w_en ? '0 : p_rdata;
        end else if (acc_cnt == TO_C) begin
          state_nx     = IDLE;
          acc_cnt_nx   = '0;
          p_sel_nx     = 1'b0;
          p_enable_nx  = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
        end else begin
          acc_cnt_nx = acc_cnt + CW'(1);
        end
      end
      default: begin
        state_nx    = IDLE;
        p_sel_nx    = 1'b0;
        p_enable_nx = 1'b0;
      end
    endcase
  end

  // State, counter and all registered outputs; async reset aborts silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      p_sel     <= 1'b0;
      p_enable  <= 1'b0;
      p_w_en    <= 1'b0;
      p_add     <= '0;
      p_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      acc_cnt   <= acc_cnt_nx;
      p_sel     <= p_sel_nx;
      p_enable  <= p_enable_nx;
      p_w_en    <= p_w_en_nx;
      p_add     <= p_add_nx;
      p_wdata   <= p_wdata_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
      rsp_rdata <= rsp_rdata_nx;
    end
  end

endmodule
